piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Downstream stage of the 4-bit parallel-in/parallel-out register: takes its parallel word and shifts it out one bit per cycle on a serial link.
- Valid/ready load handshake on the parallel side; valid/ready with a last-bit marker on the serial side.
- Supports back-to-back words with no idle cycle between frames.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range 2 to 32.
- MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- data_in  input  WIDTH  parallel word from the upstream register
- load_valid  input  1  data_in holds a word to send
- load_ready  output  1  serializer accepts a word this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out is meaningful
- ser_last  output  1  final beat of the current frame
- ser_ready  input  1  downstream consumes the current beat
- busy  output  1  a frame is in progress

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: ser_out=0, ser_valid=0, ser_last=0, busy=0, state=IDLE, shift register=0, bit counter=0. load_ready=0 while rst is high.
- States:
  - IDLE: ser_valid=0, ser_out=0, load_ready=1.
  - SHIFT: ser_valid=1, busy=1.
- Transfers:
  - Load transfer: load_valid && load_ready at a clock edge.
  - Beat transfer: ser_valid && ser_ready at a clock edge.
- Load: on a load transfer, data_in is captured, counter is set to 0, and the state goes to SHIFT. The first bit appears on ser_out in the next cycle (1-cycle latency).
- Bit order: MSB_FIRST=1 sends data_in[WIDTH-1] down to [0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
- Advance: on each beat transfer the counter increments and the next bit is presented. When ser_ready=0, ser_out, ser_valid and ser_last hold unchanged (stall of any length).
- ser_last is 1 exactly on the beat with counter == WIDTH-1 and 0 otherwise.
- Final beat, no new word: if a beat transfer happens on the last beat and no load transfer happens, the state returns to IDLE.
- Back-to-back: load_ready is also 1 in SHIFT when ser_last && ser_ready.
  - A load transfer on that edge loads the new word and stays in SHIFT.
  - The new word's first bit appears the next cycle, with no gap.
- In SHIFT when not on the final transferring beat, load_ready=0. load_valid is ignored and data_in may change freely.
- Counter width is clog2(WIDTH); it never counts past WIDTH-1 (no wrap-around within a frame).
- Reset mid-frame aborts the frame immediately on that edge. No ser_last is issued for the aborted word, and the next cycle has ser_valid=0.
- rst has priority over every simultaneous load or beat transfer.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Adds a PARITY state after the last data bit.
  - Sends one extra beat carrying the even-parity bit (XOR of the captured word).
  - ser_last moves from the final data beat to the parity beat.
  - The back-to-back load_ready condition becomes (state==PARITY && ser_ready).
  - Frame length is WIDTH+1 beats.
- Not defined: no PARITY state and no parity logic; frame length is WIDTH beats.

Test Plan:
- Reset then load (WIDTH=4, MSB_FIRST=1): rst high 2 cycles, then load 4'b1010 with ser_ready=1 -> ser_out 1,0,1,0 on the 4 cycles after the load edge; ser_last only on the 4th; then ser_valid=0 and load_ready=1.
- Stall: load 4'b1100, hold ser_ready=0 for 3 cycles on the 2nd beat -> ser_out stays 1 with ser_valid=1 throughout; the sequence then resumes 0,0 with ser_last on the final 0; total 7 valid cycles.
- Back-to-back: load_valid held high with 4'b1100 then 4'b0111 -> 8 consecutive valid beats 1,1,0,0,0,1,1,1; ser_last on beats 4 and 8; load_ready high only at beat 4 and in IDLE.
- Busy ignore: load 4'b1010, then present 4'b0101 with load_valid=1 mid-frame -> load_ready=0; output stays 1,0,1,0 and 4'b0101 is taken only at the final beat.
- Reset mid-frame: load 4'b1111, assert rst after the 2nd beat -> next cycle ser_valid=0, ser_last never asserted, busy=0; a following load of 4'b0011 serializes 0,0,1,1 correctly.
- With PISO_PARITY_EN: load 4'b0111 -> beats 0,1,1,1,1 (parity=1), ser_last on beat 5; load 4'b1010 -> parity beat 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage behind a WIDTH-bit register.
// A word is accepted over a valid/ready load handshake and sent one bit per
// cycle over a valid/ready serial link, with ser_last on the final beat.
// Back-to-back frames are supported with no idle beat between them.
// Optional feature: define PISO_PARITY_EN to append one even-parity beat
// (XOR of the captured word) to every frame; ser_last then marks that beat.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,  // legal range 2..32
  parameter int unsigned MSB_FIRST = 1   // 1: bit WIDTH-1 first, 0: bit 0 first
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;     // bits still to be sent after the current one
  logic [CNT_W-1:0] cnt_q;       // index of the data beat currently presented
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_last_q;
  logic             busy_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;    // even parity of the captured word
`endif

  logic             beat_fire;
  logic             load_fire;
  logic             frame_end;
  logic             last_data;
  logic             first_bit_d;
  logic [WIDTH-1:0] load_rest_d;
  logic             next_bit_d;
  logic [WIDTH-1:0] shift_adv_d;
  logic [CNT_W-1:0] cnt_inc_d;

  // Transfer qualifiers, bit-order selection and the load_ready handshake.
  // load_ready must be combinational: it depends on ser_ready in the same
  // cycle so a new word can be taken on the edge that retires the last beat.
  always_comb begin
    beat_fire   = ser_valid_q && ser_ready;
    last_data   = (cnt_q == CNT_LAST);
    cnt_inc_d   = cnt_q + CNT_ONE;
`ifdef PISO_PARITY_EN
    frame_end   = (state_q == PARITY);
`else
    frame_end   = (state_q == SHIFT) && ser_last_q;
`endif
    load_ready  = !rst && ((state_q == IDLE) || (frame_end && ser_ready));
    load_fire   = load_valid && load_ready;
    if (MSB_FIRST != 0) begin
      first_bit_d = data_in[WIDTH-1];
      load_rest_d = data_in << 1;
      next_bit_d  = shift_q[WIDTH-1];
      shift_adv_d = shift_q << 1;
    end else begin
      first_bit_d = data_in[0];
      load_rest_d = data_in >> 1;
      next_bit_d  = shift_q[0];
      shift_adv_d = shift_q >> 1;
    end
  end

  // Serializer FSM with registered serial-side outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; rst is tested first so it overrides any
  // load or beat transfer on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (load_fire) begin
      // New word: present its first bit next cycle (also covers back-to-back).
      state_q     <= SHIFT;
      shift_q     <= load_rest_d;
      cnt_q       <= '0;
      ser_out_q   <= first_bit_d;
      ser_valid_q <= 1'b1;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q    <= ^data_in;
`endif
    end else if (beat_fire) begin
      case (state_q)
        SHIFT: begin
          if (!last_data) begin
            cnt_q      <= cnt_inc_d;
            ser_out_q  <= next_bit_d;
            shift_q    <= shift_adv_d;
`ifdef PISO_PARITY_EN
            ser_last_q <= 1'b0;
`else
            ser_last_q <= (cnt_inc_d == CNT_LAST);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_q    <= PARITY;
            ser_out_q  <= parity_q;
            ser_last_q <= 1'b1;
`else
            state_q     <= IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_q     <= IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
`endif
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives two serializers (WIDTH=4 MSB-first and WIDTH=5
// LSB-first) from shared handshake inputs and compares every output, every
// cycle, against a frame-level model: each accepted word becomes a list of
// beats in send order that the serial side drains one beat per transfer.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       ser_ready;
  logic [3:0] data_m;
  logic [4:0] data_l;
  logic [1:0] load_ready, ser_out, ser_valid, ser_last, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: pending beats per DUT, bit 0 of seq is the beat on the wire.
  logic [63:0] seq [2];
  int          n   [2];

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_m), .load_valid(load_valid),
    .load_ready(load_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_last(ser_last[0]), .ser_ready(ser_ready), .busy(busy[0]));

  piso_serializer #(.WIDTH(5), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_l), .load_valid(load_valid),
    .load_ready(load_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_last(ser_last[1]), .ser_ready(ser_ready), .busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  // Beats of one frame in send order, parity beat appended when enabled.
  function automatic logic [63:0] frame(input logic [31:0] d, input int w, input bit msb);
    logic [63:0] f;
    logic        p;
    f = '0;
    p = 1'b0;
    for (int i = 0; i < w; i++) begin
      f[i] = msb ? d[w-1-i] : d[i];
      p    = p ^ d[i];
    end
    if (PAR != 0) f[w] = p;
    return f;
  endfunction

  // One clock: apply inputs, compare at the falling edge, advance the model
  // at the rising edge, then move 1 time unit past it.
  task automatic step(input bit r, input bit lv, input logic [31:0] d, input bit sr);
    bit          mv, ml, mr;
    logic        mo;
    logic [31:0] wd;
    rst        = r;
    load_valid = lv;
    data_m     = d[3:0];
    data_l     = d[4:0];
    ser_ready  = sr;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mv = (n[k] > 0);
      mo = mv ? seq[k][0] : 1'b0;
      ml = (n[k] == 1);
      mr = !r && ((n[k] == 0) || ((n[k] == 1) && sr));
      check($sformatf("dut%0d ser_valid", k), 32'(ser_valid[k]), 32'(mv));
      check($sformatf("dut%0d ser_out", k), 32'(ser_out[k]), 32'(mo));
      check($sformatf("dut%0d ser_last", k), 32'(ser_last[k]), 32'(ml));
      check($sformatf("dut%0d busy", k), 32'(busy[k]), 32'(mv));
      check($sformatf("dut%0d load_ready", k), 32'(load_ready[k]), 32'(mr));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mr = !r && ((n[k] == 0) || ((n[k] == 1) && sr));
      if (r) begin
        n[k]   = 0;
        seq[k] = '0;
      end else begin
        if ((n[k] > 0) && sr) begin
          seq[k] = seq[k] >> 1;
          n[k]   = n[k] - 1;
        end
        if (lv && mr) begin
          wd     = (k == 0) ? 32'(d[3:0]) : 32'(d[4:0]);
          seq[k] = frame(wd, width_of(k), (k == 0));
          n[k]   = width_of(k) + PAR;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_bits;
    int         valid_cnt;
    for (int k = 0; k < 2; k++) begin
      n[k]   = 0;
      seq[k] = '0;
    end
    rst        = 1'b1;
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    data_m     = '0;
    data_l     = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then send 1010 with the link always ready.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'hA, 1'b1);
    step(1'b0, 1'b1, 32'hA, 1'b1);
    exp_bits = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      check("plan_load ser_out", 32'(ser_out[0]), 32'(exp_bits[3-i]));
      check("plan_load ser_last", 32'(ser_last[0]), 32'(i == 3));
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    check("plan_load idle ser_valid", 32'(ser_valid[0]), 32'(PAR != 0));
    idle(4);

    // Stall three cycles on the second beat of 1100.
    step(1'b0, 1'b1, 32'hC, 1'b1);
    valid_cnt = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("plan_stall held bit", 32'(ser_out[0]), 32'h1);
    for (int i = 0; i < 8; i++) begin
      if (ser_valid[0]) valid_cnt++;
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    check("plan_stall valid beats after stall", 32'(valid_cnt), 32'(3 + PAR));
    idle(3);

    // Back-to-back: 1100 then 0111 with load_valid held high.
    step(1'b0, 1'b1, 32'hC, 1'b1);
    for (int i = 0; i < 4 + PAR; i++) step(1'b0, 1'b1, 32'h7, 1'b1);
    idle(8);

    // New word presented mid-frame must wait for the final beat.
    step(1'b0, 1'b1, 32'hA, 1'b1);
    for (int i = 0; i < 4 + PAR; i++) step(1'b0, 1'b1, 32'h5, 1'b1);
    idle(8);

    // Reset in the middle of a 1111 frame, then send 0011.
    step(1'b0, 1'b1, 32'hF, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h3, 1'b1);
    check("plan_abort ser_valid", 32'(ser_valid[0]), 32'h0);
    check("plan_abort busy", 32'(busy[0]), 32'h0);
    step(1'b0, 1'b1, 32'h3, 1'b1);
    idle(8);

    // Randomized traffic: sporadic resets, loads and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
           $urandom, ($urandom_range(0, 9) < 6));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
